seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds an 8-nibble double-buffered digit store and steps a 3-bit digit index at a fixed refresh rate. It presents the current nibble to the hex-to-segment decoder and the index to the 3-to-8 digit-select decoder. Software-side logic loads the shadow buffer and requests a commit, which is applied only at a frame boundary so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment
// display. It holds a double-buffered digit store (shadow/active) and steps a
// digit index once every CLK_DIV clocks. A commit request copies shadow to
// active only at the frame boundary (index wrap 7->0), so the display never
// shows a half-updated frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression).

module seg_scan_ctrl #(
   parameter int CLK_DIV    = 100000,
   parameter int NUM_DIGITS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       commit_req,
   input  logic       blank,
   output logic [3:0] digit_val,
   output logic [2:0] digit_sel,
   output logic       digit_en,
   output logic       commit_pending,
   output logic       frame_tick
);

   localparam int             IW       = $clog2(NUM_DIGITS);
   localparam int             PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0] prescaler;
   logic [IW-1:0] idx;
   logic [3:0]    shadow [NUM_DIGITS];
   logic [3:0]    active [NUM_DIGITS];
   logic          en_q;
   logic          step_idx;
   logic          wrap;
   logic          do_copy;

   assign step_idx = (prescaler == PRE_LAST);
   assign wrap     = step_idx && (idx == IDX_LAST);
   // A request arriving on the wrap cycle itself is honoured immediately.
   assign do_copy  = wrap && (commit_pending || commit_req);

   // Prescaler, digit index, frame tick and registered enable.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         prescaler  <= '0;
         idx        <= '0;
         frame_tick <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         frame_tick <= wrap;
         en_q       <= ~blank;
         if (step_idx) begin
            prescaler <= '0;
            idx       <= idx + 1'b1;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   // Shadow writes, commit tracking and frame-boundary copy to the active bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: both digit banks are small register files that must read as
         // zero after reset, so they are cleared here rather than left as RAM.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         commit_pending <= 1'b0;
      end else begin
         if (wr_en) begin
            shadow[wr_addr] <= wr_data;
         end
         if (do_copy) begin
            // Copy sees pre-edge shadow; a same-edge write waits for a later commit.
            active         <= shadow;
            commit_pending <= 1'b0;
         end else if (commit_req) begin
            commit_pending <= 1'b1;
         end
      end
   end

   assign digit_sel = idx;
   assign digit_val = active[idx];

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_blank;

   // Suppress a digit when it and every more-significant digit are zero.
   always_comb begin
      // NOTE: the default comes first so every path assigns lz_blank and no
      // latch is inferred.
      lz_blank = (idx != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((IW'(i) >= idx) && (active[i] != 4'h0)) begin
            lz_blank = 1'b0;
         end
      end
   end

   assign digit_en = en_q & ~lz_blank;
`else
   assign digit_en = en_q;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with CLK_DIV=4 (8-cycle... 32-cycle frame).
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the build.

module tb_seg_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       commit_req;
   logic       blank;
   logic [3:0] digit_val;
   logic [2:0] digit_sel;
   logic       digit_en;
   logic       commit_pending;
   logic       frame_tick;

   int         total = 0;
   int         bad   = 0;
   int         t     = 0;   // edges since reset release
   logic [3:0] act_exp [8];

   seg_scan_ctrl #(.CLK_DIV(DIV), .NUM_DIGITS(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit_req     (commit_req),
      .blank          (blank),
      .digit_val      (digit_val),
      .digit_sel      (digit_sel),
      .digit_en       (digit_en),
      .commit_pending (commit_pending),
      .frame_tick     (frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   function automatic int sel_m();
      return (t / DIV) % 8;
   endfunction

   function automatic logic en_m(input int s);
      if (!LZB || s == 0) return 1'b1;
      for (int j = s; j < 8; j++) begin
         if (act_exp[j] != 4'h0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic wait_phase(input int p);
      while ((t % FRAME) != p) step();
   endtask

   task automatic write_digit(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = 4'(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic commit_pulse();
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
   endtask

   // Check one full frame starting at phase 0.
   task automatic check_frame(input string tag);
      for (int k = 0; k < FRAME; k++) begin
         check({tag, "_sel"}, digit_sel, sel_m());
         check({tag, "_val"}, digit_val, act_exp[sel_m()]);
         check({tag, "_en"},  digit_en,  en_m(sel_m()));
         step();
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_sel"},  digit_sel, 0);
      check({tag, "_val"},  digit_val, 0);
      check({tag, "_en"},   digit_en, 0);
      check({tag, "_pend"}, commit_pending, 0);
      check({tag, "_tick"}, frame_tick, 0);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      commit_req = 1'b0; blank = 1'b0;
      for (int i = 0; i < 8; i++) act_exp[i] = 4'h0;

      // Reset state
      step(); step();
      check_reset_state("rst");
      reset = 1'b0;
      t = 0;

      // Free-running scan with empty buffers
      for (int k = 1; k <= FRAME + 1; k++) begin
         step();
         check("scan_sel",  digit_sel, sel_m());
         check("scan_tick", frame_tick, ((t % FRAME) == 0) ? 1 : 0);
         check("scan_val",  digit_val, 0);
         check("scan_en",   digit_en, en_m(sel_m()));
      end

      // Shadow writes without commit never reach the display
      for (int i = 0; i < 8; i++) write_digit(i, i + 8);
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         check("nocommit_val",  digit_val, 0);
         check("nocommit_pend", commit_pending, 0);
      end

      // Mid-frame commit applies at the wrap
      wait_phase(10);
      commit_pulse();
      check("commit_pend_set", commit_pending, 1);
      while ((t % FRAME) != FRAME - 1) begin
         step();
         check("commit_pend_hold", commit_pending, 1);
         check("commit_val_old", digit_val, 0);
      end
      for (int i = 0; i < 8; i++) act_exp[i] = 4'(i + 8);
      step();
      check("wrap_tick", frame_tick, 1);
      check("wrap_pend", commit_pending, 0);
      check("wrap_sel",  digit_sel, 0);
      check("wrap_val",  digit_val, 4'h8);
      for (int k = 1; k < FRAME; k++) begin
         step();
         check("committed_val", digit_val, act_exp[sel_m()]);
      end

      // Write and commit on the same wrap edge: copy uses pre-edge shadow
      write_digit(3, 4'hA);
      wait_phase(FRAME - 1);
      commit_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h5;
      act_exp[3] = 4'hA;
      step();
      commit_req = 1'b0; wr_en = 1'b0;
      check("same_edge_pend", commit_pending, 0);
      check("same_edge_tick", frame_tick, 1);
      wait_phase(12);
      check("same_edge_sel3", digit_sel, 3);
      check("same_edge_val3", digit_val, 4'hA);
      commit_pulse();
      check("recommit_pend", commit_pending, 1);
      act_exp[3] = 4'h5;
      wait_phase(12);
      check("recommit_val3", digit_val, 4'h5);
      check("recommit_pend_clr", commit_pending, 0);

      // Blank for 6 cycles: enable drops one edge after blank is raised
      wait_phase(5);
      check("blank_pre_en", digit_en, 1);
      blank = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("blank_en", digit_en, 0);
         check("blank_sel", digit_sel, sel_m());
      end
      blank = 1'b0;
      check("blank_last_en", digit_en, 0);
      step();
      check("blank_release_en", digit_en, en_m(sel_m()));

      // Leading-zero pattern: only digit 3 nonzero
      for (int i = 0; i < 8; i++) write_digit(i, (i == 3) ? 1 : 0);
      commit_pulse();
      wait_phase(FRAME - 1);
      for (int i = 0; i < 8; i++) act_exp[i] = (i == 3) ? 4'h1 : 4'h0;
      step();
      check_frame("lz_pat");

      // All digits zero
      for (int i = 0; i < 8; i++) write_digit(i, 0);
      commit_pulse();
      wait_phase(FRAME - 1);
      for (int i = 0; i < 8; i++) act_exp[i] = 4'h0;
      step();
      check_frame("lz_zero");

      // Reset mid-frame drops a pending commit and restarts the scan
      write_digit(2, 7);
      commit_pulse();
      check("midrst_pend_before", commit_pending, 1);
      wait_phase(20);
      reset = 1'b1;
      step();
      check_reset_state("midrst");
      reset = 1'b0;
      t = 0;
      for (int k = 1; k <= FRAME + 4; k++) begin
         step();
         check("midrst_val",  digit_val, 0);
         check("midrst_pend", commit_pending, 0);
         check("midrst_sel",  digit_sel, sel_m());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
